// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and burst sequencer for the data memory
//
// Port 0 is the pipeline MEM stage and port 1 is the debug/loader port. The
// arbiter grants one of them at a time and runs a 1..2^LEN_W beat burst into
// the shared memory.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   rX_req                     request, held until final ack or dropped to abort
//   rX_we, rX_addr, rX_len     burst direction, base address, beats-1 (sampled at grant)
//   rX_wdata                   live write data for the current beat
//   rX_gnt                     high while port X owns the running burst
//   rX_ack                     beat strobe, the memory access happens this cycle
//   rX_rdata                   memory read data on read acks, else 0
//   mem_MW, mem_addr, mem_datain  memory write enable, address, write data
//   mem_dataout                memory combinational read data
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_MW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic              owner;
    logic              last;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat;

    logic              pick;
    logic              owner_req;
    logic [DATA_W-1:0] owner_wdata;
    logic              active;

    // On a tie the port that did not own the previous burst wins; otherwise
    // the sole requester wins (r1_req is 1 exactly when port 1 is alone).
    always_comb begin
        if (r0_req && r1_req) begin
            pick = ~last;
        end else begin
            pick = r1_req;
        end
    end

    assign owner_req   = owner ? r1_req : r0_req;
    assign owner_wdata = owner ? r1_wdata : r0_wdata;

    // A beat happens only in BURST while the owner still requests. Gating with
    // rst keeps every output quiet and blocks writes in a reset cycle.
    assign active = !rst && (state == BURST) && owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            we_q   <= 1'b0;
            base_q <= '0;
            len_q  <= '0;
            beat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner  <= pick;
                        we_q   <= pick ? r1_we   : r0_we;
                        base_q <= pick ? r1_addr : r0_addr;
                        len_q  <= pick ? r1_len  : r0_len;
                        beat   <= '0;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        // Abort: beats already acked stay committed.
                        last  <= owner;
                        state <= IDLE;
                    end else if (beat == len_q) begin
                        last  <= owner;
                        state <= IDLE;
                    end else begin
                        beat <= beat + LEN_W'(1);
                    end
                end
            endcase
        end
    end

    assign r0_gnt = active && (owner == 1'b0);
    assign r1_gnt = active && (owner == 1'b1);
    assign r0_ack = r0_gnt;
    assign r1_ack = r1_gnt;

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign mem_addr   = active ? (base_q + ADDR_W'(beat)) : '0;
    assign mem_MW     = active && we_q;
    assign mem_datain = (active && we_q) ? owner_wdata : '0;

    assign r0_rdata = (r0_ack && !we_q) ? mem_dataout : '0;
    assign r1_rdata = (r1_ack && !we_q) ? mem_dataout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [5:0]  r0_addr, r1_addr;
    logic [2:0]  r0_len, r1_len;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_ack, r1_gnt, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_MW;
    logic [5:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;

    logic [31:0] mem [64];
    logic        mem_init;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (mem_MW) begin
            mem[mem_addr] <= mem_datain;
        end
    end
    assign mem_dataout = mem[mem_addr];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_len(r0_len),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_len(r1_len),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_MW(mem_MW), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    // Move to 1 time unit after the next rising edge; inputs are driven here
    // and outputs are sampled 1 unit later, well before the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_len = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_len = 0; r1_wdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; mem_init = 1;
        next_cycle();
        // Requests during reset must not be granted.
        r0_req = 1; r1_req = 1; r0_we = 1; r0_wdata = 32'hDEAD;
        #1;
        checks++;
        if ({r0_gnt, r0_ack, r1_gnt, r1_ack, mem_MW} !== 5'b0 || mem_addr !== 6'd0 ||
            mem_datain !== 32'd0 || r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got gnt0=%0b ack0=%0b gnt1=%0b ack1=%0b MW=%0b addr=%0d din=%0h exp all 0",
                     r0_gnt, r0_ack, r1_gnt, r1_ack, mem_MW, mem_addr, mem_datain);
        end
        next_cycle();
        clear_inputs();
        mem_init = 0;
        next_cycle();
        rst = 0;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, mem_MW} !== 3'b0) begin
            failures++;
            $display("FAIL reset_idle got gnt0=%0b gnt1=%0b MW=%0b exp 0", r0_gnt, r1_gnt, mem_MW);
        end
    endtask

    task automatic test_single_read();
        next_cycle();
        r0_req = 1; r0_we = 0; r0_addr = 5; r0_len = 0;
        #1;
        checks++;
        if (r0_gnt !== 1'b0) begin
            failures++; $display("FAIL read_idle_gnt got=%0b exp=0", r0_gnt);
        end
        next_cycle();
        #1;
        checks++;
        if (r0_gnt !== 1'b1 || r0_ack !== 1'b1 || r0_rdata !== 32'd5 || mem_MW !== 1'b0 || mem_addr !== 6'd5) begin
            failures++;
            $display("FAIL read_beat got gnt=%0b ack=%0b rdata=%0d MW=%0b addr=%0d exp 1 1 5 0 5",
                     r0_gnt, r0_ack, r0_rdata, mem_MW, mem_addr);
        end
        next_cycle();
        r0_req = 0;
        #1;
        checks++;
        if (r0_gnt !== 1'b0 || r0_ack !== 1'b0 || r0_rdata !== 32'd0) begin
            failures++; $display("FAIL read_one_cycle got gnt=%0b ack=%0b rdata=%0d exp 0 0 0", r0_gnt, r0_ack, r0_rdata);
        end
    endtask

    task automatic test_write_wrap();
        logic [5:0] exp_addr;
        next_cycle();
        r1_req = 1; r1_we = 1; r1_addr = 62; r1_len = 3;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            r1_wdata = 32'hA0 + 32'(k);
            exp_addr = 6'(62 + k);
            #1;
            checks++;
            if (r1_ack !== 1'b1 || r1_gnt !== 1'b1 || mem_MW !== 1'b1 || mem_addr !== exp_addr ||
                mem_datain !== 32'hA0 + 32'(k)) begin
                failures++;
                $display("FAIL wrap_beat%0d got ack=%0b MW=%0b addr=%0d din=%0h exp 1 1 %0d %0h",
                         k, r1_ack, mem_MW, mem_addr, mem_datain, exp_addr, 32'hA0 + 32'(k));
            end
            checks++;
            if (r0_gnt !== 1'b0 || r0_ack !== 1'b0 || r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin
                failures++;
                $display("FAIL wrap_r0_quiet%0d got gnt0=%0b ack0=%0b rdata0=%0h rdata1=%0h exp 0",
                         k, r0_gnt, r0_ack, r0_rdata, r1_rdata);
            end
        end
        next_cycle();
        r1_req = 0; r1_we = 0; r1_wdata = 0;
        #1;
        checks++;
        if (r1_ack !== 1'b0) begin
            failures++; $display("FAIL wrap_end_ack got=%0b exp=0", r1_ack);
        end
        checks++;
        if (mem[62] !== 32'hA0 || mem[63] !== 32'hA1 || mem[0] !== 32'hA2 || mem[1] !== 32'hA3) begin
            failures++;
            $display("FAIL wrap_mem got %0h %0h %0h %0h exp a0 a1 a2 a3", mem[62], mem[63], mem[0], mem[1]);
        end
    endtask

    task automatic test_alternate();
        logic e0, e1;
        test_reset();
        r0_req = 1; r0_we = 0; r0_addr = 3; r0_len = 0;
        r1_req = 1; r1_we = 0; r1_addr = 7; r1_len = 0;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                next_cycle();
                #1;
            end
            e0 = (c % 4) == 1;
            e1 = (c % 4) == 3;
            checks++;
            if (r0_gnt !== e0 || r1_gnt !== e1) begin
                failures++;
                $display("FAIL alt_cycle%0d got gnt0=%0b gnt1=%0b exp %0b %0b", c, r0_gnt, r1_gnt, e0, e1);
            end
            if (e1) begin
                checks++;
                if (r1_rdata !== 32'd7) begin
                    failures++; $display("FAIL alt_rdata1 got=%0d exp=7", r1_rdata);
                end
            end
        end
        // Cycle 8 is an IDLE cycle; drop both so nothing is granted next.
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_abort();
        next_cycle();
        r0_req = 1; r0_we = 1; r0_addr = 10; r0_len = 3;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            r0_wdata = 32'hB0 + 32'(k);
            #1;
            checks++;
            if (r0_ack !== 1'b1 || mem_MW !== 1'b1 || mem_addr !== 6'(10 + k)) begin
                failures++;
                $display("FAIL abort_beat%0d got ack=%0b MW=%0b addr=%0d exp 1 1 %0d", k, r0_ack, mem_MW, mem_addr, 10 + k);
            end
        end
        next_cycle();
        r0_req = 0; r0_wdata = 32'hBB;
        #1;
        checks++;
        if (r0_gnt !== 1'b0 || r0_ack !== 1'b0 || mem_MW !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop got gnt=%0b ack=%0b MW=%0b exp 0 0 0", r0_gnt, r0_ack, mem_MW);
        end
        // State must be IDLE now: a new r1 request is granted one cycle later.
        next_cycle();
        r0_we = 0; r0_wdata = 0;
        r1_req = 1; r1_we = 0; r1_addr = 12; r1_len = 0;
        next_cycle();
        #1;
        checks++;
        if (r1_gnt !== 1'b1 || r1_rdata !== 32'd12) begin
            failures++; $display("FAIL abort_idle got gnt1=%0b rdata1=%0d exp 1 12", r1_gnt, r1_rdata);
        end
        next_cycle();
        clear_inputs();
        checks++;
        if (mem[10] !== 32'hB0 || mem[11] !== 32'hB1 || mem[12] !== 32'd12 || mem[13] !== 32'd13) begin
            failures++;
            $display("FAIL abort_mem got %0h %0h %0h %0h exp b0 b1 c d", mem[10], mem[11], mem[12], mem[13]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        // Port 0 owns a burst first so the pointer would favour port 1 without reset.
        next_cycle();
        r0_req = 1; r0_we = 0; r0_addr = 1; r0_len = 0;
        next_cycle();
        next_cycle();
        r0_req = 0;
        next_cycle();
        r1_req = 1; r1_we = 1; r1_addr = 20; r1_len = 7;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            r1_wdata = 32'hC0 + 32'(k);
        end
        next_cycle();
        r1_wdata = 32'hC2;
        rst = 1;
        #1;
        checks++;
        if (mem_MW !== 1'b0 || r1_gnt !== 1'b0 || r1_ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_during got MW=%0b gnt1=%0b ack1=%0b exp 0", mem_MW, r1_gnt, r1_ack);
        end
        next_cycle();
        rst = 0;
        r1_we = 0; r1_addr = 21; r1_len = 0;
        r0_req = 1; r0_we = 0; r0_addr = 20; r0_len = 0;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, r0_ack, r1_ack, mem_MW} !== 5'b0 || mem_addr !== 6'd0 || mem_datain !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_after got gnt0=%0b gnt1=%0b MW=%0b addr=%0d exp all 0", r0_gnt, r1_gnt, mem_MW, mem_addr);
        end
        next_cycle();
        #1;
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || r0_rdata !== 32'hC0) begin
            failures++;
            $display("FAIL rstmid_tie got gnt0=%0b gnt1=%0b rdata0=%0h exp 1 0 c0", r0_gnt, r1_gnt, r0_rdata);
        end
        ok = (mem[20] === 32'hC0) && (mem[21] === 32'hC1);
        for (int a = 22; a < 28; a++) if (mem[a] !== 32'(a)) ok = 0;
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rstmid_mem got m20=%0h m21=%0h m22=%0h exp c0 c1 16", mem[20], mem[21], mem[22]);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back_hold();
        next_cycle();
        r0_req = 1; r0_we = 0; r0_addr = 40; r0_len = 7;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k == 0) begin
                r1_req = 1; r1_we = 0; r1_addr = 50; r1_len = 0;
            end
            #1;
            checks++;
            if (r0_ack !== 1'b1 || r0_rdata !== 32'(40 + k) || r1_gnt !== 1'b0 || r1_ack !== 1'b0) begin
                failures++;
                $display("FAIL hold_beat%0d got ack0=%0b rdata0=%0d gnt1=%0b exp 1 %0d 0",
                         k, r0_ack, r0_rdata, r1_gnt, 40 + k);
            end
        end
        next_cycle();
        r0_req = 0;
        #1;
        checks++;
        if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
            failures++; $display("FAIL hold_turnaround got gnt0=%0b gnt1=%0b exp 0 0", r0_gnt, r1_gnt);
        end
        next_cycle();
        #1;
        checks++;
        if (r1_gnt !== 1'b1 || r1_rdata !== 32'd50) begin
            failures++; $display("FAIL hold_r1_grant got gnt1=%0b rdata1=%0d exp 1 50", r1_gnt, r1_rdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        rst = 1; mem_init = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_wrap();
        test_alternate();
        test_abort();
        test_reset_mid_burst();
        test_back_to_back_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
